// File: rtl/axi_drain_pkg.sv
// Shared types for the AXI drain/isolation controller.
package axi_drain_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DRAIN    = 2'd1,
      ISOLATED = 2'd2
   } drain_state_e;
endpackage

// File: rtl/axi_drain_counter.sv
// Outstanding-transaction up/down counter with max/zero flags.
// A completion at zero holds the count and raises a registered one-cycle underflow pulse.
module axi_drain_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         is_max,
   output logic         is_zero,
   output logic         underflow
);

   assign is_zero = (cnt == '0);
   assign is_max  = &cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         underflow <= 1'b0;
      end else begin
         underflow <= dec & ~inc & is_zero;
         if (inc & ~dec)
            cnt <= cnt + W'(1);
         else if (dec & ~inc & ~is_zero)
            cnt <= cnt - W'(1);
      end
   end

endmodule

// File: rtl/axi_drain_ctrl.sv
// AW/AR request gate with drain FSM: quiesces the port on isolate_i and acknowledges once empty.
// Gating is zero-latency pass-through decided from registered state and counters only.
module axi_drain_ctrl
   import axi_drain_pkg::*;
#(
   parameter int COUNTER_SIZE = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    isolate_i,
   input  logic                    slv_aw_valid_i,
   output logic                    slv_aw_ready_o,
   output logic                    mst_aw_valid_o,
   input  logic                    mst_aw_ready_i,
   input  logic                    slv_ar_valid_i,
   output logic                    slv_ar_ready_o,
   output logic                    mst_ar_valid_o,
   input  logic                    mst_ar_ready_i,
   input  logic                    b_done_i,
   input  logic                    r_done_i,
   output logic                    isolated_o,
   output logic                    busy_o,
   output logic [COUNTER_SIZE-1:0] aw_cnt_o,
   output logic [COUNTER_SIZE-1:0] ar_cnt_o,
   output logic                    err_o
);

   drain_state_e state, state_nxt;
   logic aw_max, aw_zero, aw_uf, aw_open, aw_accept;
   logic ar_max, ar_zero, ar_uf, ar_open, ar_accept;

   axi_drain_counter #(.W(COUNTER_SIZE)) u_aw_cnt (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .inc       (aw_accept),
      .dec       (b_done_i),
      .cnt       (aw_cnt_o),
      .is_max    (aw_max),
      .is_zero   (aw_zero),
      .underflow (aw_uf)
   );

   axi_drain_counter #(.W(COUNTER_SIZE)) u_ar_cnt (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .inc       (ar_accept),
      .dec       (r_done_i),
      .cnt       (ar_cnt_o),
      .is_max    (ar_max),
      .is_zero   (ar_zero),
      .underflow (ar_uf)
   );

   // Closing at max is what makes counter overflow impossible.
   assign aw_open        = (state == RUN) && !aw_max;
   assign ar_open        = (state == RUN) && !ar_max;
   assign mst_aw_valid_o = aw_open & slv_aw_valid_i;
   assign slv_aw_ready_o = aw_open & mst_aw_ready_i;
   assign mst_ar_valid_o = ar_open & slv_ar_valid_i;
   assign slv_ar_ready_o = ar_open & mst_ar_ready_i;
   assign aw_accept      = mst_aw_valid_o & mst_aw_ready_i;
   assign ar_accept      = mst_ar_valid_o & mst_ar_ready_i;

   assign busy_o     = !aw_zero || !ar_zero;
   assign isolated_o = (state == ISOLATED);
   assign err_o      = aw_uf | ar_uf;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         state <= RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (isolate_i) state_nxt = DRAIN;
         DRAIN: begin
            if (!isolate_i)
               state_nxt = RUN;
            else if (aw_zero && ar_zero)
               state_nxt = ISOLATED;
         end
         ISOLATED: if (!isolate_i) state_nxt = RUN;
         default:  state_nxt = RUN;
      endcase
   end

endmodule

// File: tb/tb_axi_drain_ctrl.sv
// Directed self-checking bench for axi_drain_ctrl (default size plus a COUNTER_SIZE=2 instance).
module tb_axi_drain_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Instance A: COUNTER_SIZE = 4
   logic isolate, aw_valid, aw_ready, ar_valid, ar_ready, b_done, r_done;
   logic s_aw_ready, m_aw_valid, s_ar_ready, m_ar_valid, isolated, busy, err;
   logic [3:0] aw_cnt, ar_cnt;

   // Instance B: COUNTER_SIZE = 2
   logic b_isolate, b_aw_valid, b_aw_ready, b_ar_valid, b_ar_ready, b_b_done, b_r_done;
   logic b_s_aw_ready, b_m_aw_valid, b_s_ar_ready, b_m_ar_valid, b_isolated, b_busy, b_err;
   logic [1:0] b_aw_cnt, b_ar_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   axi_drain_ctrl #(.COUNTER_SIZE(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .isolate_i(isolate),
      .slv_aw_valid_i(aw_valid), .slv_aw_ready_o(s_aw_ready),
      .mst_aw_valid_o(m_aw_valid), .mst_aw_ready_i(aw_ready),
      .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(s_ar_ready),
      .mst_ar_valid_o(m_ar_valid), .mst_ar_ready_i(ar_ready),
      .b_done_i(b_done), .r_done_i(r_done),
      .isolated_o(isolated), .busy_o(busy),
      .aw_cnt_o(aw_cnt), .ar_cnt_o(ar_cnt), .err_o(err)
   );

   axi_drain_ctrl #(.COUNTER_SIZE(2)) dut_small (
      .clk_i(clk), .rst_ni(rst_n), .isolate_i(b_isolate),
      .slv_aw_valid_i(b_aw_valid), .slv_aw_ready_o(b_s_aw_ready),
      .mst_aw_valid_o(b_m_aw_valid), .mst_aw_ready_i(b_aw_ready),
      .slv_ar_valid_i(b_ar_valid), .slv_ar_ready_o(b_s_ar_ready),
      .mst_ar_valid_o(b_m_ar_valid), .mst_ar_ready_i(b_ar_ready),
      .b_done_i(b_b_done), .r_done_i(b_r_done),
      .isolated_o(b_isolated), .busy_o(b_busy),
      .aw_cnt_o(b_aw_cnt), .ar_cnt_o(b_ar_cnt), .err_o(b_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      {isolate, aw_valid, aw_ready, ar_valid, ar_ready, b_done, r_done} = '0;
      {b_isolate, b_aw_valid, b_aw_ready, b_ar_valid, b_ar_ready, b_b_done, b_r_done} = '0;

      // Reset state; gate open so valid/ready follow their inputs
      #12;
      aw_valid = 1'b1; ar_ready = 1'b1;
      #1;
      chk("rst_aw_cnt", aw_cnt, 0);
      chk("rst_ar_cnt", ar_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_isolated", isolated, 0);
      chk("rst_err", err, 0);
      chk("rst_m_aw_valid", m_aw_valid, 1);
      chk("rst_s_ar_ready", s_ar_ready, 1);
      chk("rst_m_ar_valid", m_ar_valid, 0);
      aw_valid = 1'b0; ar_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // Pass-through: 3 AW accepts then 3 B completions
      aw_valid = 1'b1; aw_ready = 1'b1;
      tick(); chk("pt_cnt1", aw_cnt, 1); chk("pt_busy1", busy, 1);
      tick(); chk("pt_cnt2", aw_cnt, 2);
      tick(); chk("pt_cnt3", aw_cnt, 3);
      aw_valid = 1'b0; b_done = 1'b1;
      tick(); chk("pt_cnt2d", aw_cnt, 2);
      tick(); chk("pt_cnt1d", aw_cnt, 1); chk("pt_busy_last", busy, 1);
      tick(); chk("pt_cnt0", aw_cnt, 0); chk("pt_busy0", busy, 0);
      chk("pt_isolated", isolated, 0); chk("pt_err", err, 0);
      b_done = 1'b0;

      // Simultaneous accept and completion at count 5
      aw_valid = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("sim_cnt5", aw_cnt, 5);
      b_done = 1'b1;
      tick(); chk("sim_hold", aw_cnt, 5); chk("sim_err", err, 0);
      aw_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("sim_drained", aw_cnt, 0);
      b_done = 1'b0; aw_ready = 1'b0;
      tick();

      // Drain: 2 ARs outstanding, isolate raised in the cycle of the second accept
      ar_valid = 1'b1; ar_ready = 1'b1;
      tick(); chk("dr_cnt1", ar_cnt, 1);
      isolate = 1'b1; aw_valid = 1'b1;
      #1; chk("dr_same_cycle_valid", m_ar_valid, 1);
      tick();
      chk("dr_cnt2", ar_cnt, 2);
      chk("dr_ar_closed", m_ar_valid, 0);
      chk("dr_ar_ready_closed", s_ar_ready, 0);
      chk("dr_aw_closed", m_aw_valid, 0);
      chk("dr_not_iso", isolated, 0);
      ar_valid = 1'b0; aw_valid = 1'b0; r_done = 1'b1;
      tick(); chk("dr_cnt1d", ar_cnt, 1);
      tick(); chk("dr_cnt0", ar_cnt, 0); chk("dr_iso_wait", isolated, 0);
      r_done = 1'b0;
      tick(); chk("dr_iso", isolated, 1); chk("dr_busy", busy, 0);

      // Resume from ISOLATED
      ar_ready = 1'b0; ar_valid = 1'b1; isolate = 1'b0;
      #1; chk("res_still_closed", m_ar_valid, 0);
      tick(); chk("res_open", m_ar_valid, 1); chk("res_iso", isolated, 0);
      ar_valid = 1'b0;

      // Abort: isolate for 2 cycles with 1 outstanding, then drop
      aw_valid = 1'b1; aw_ready = 1'b1;
      tick(); chk("ab_cnt1", aw_cnt, 1);
      aw_valid = 1'b0; aw_ready = 1'b0; isolate = 1'b1;
      tick(); chk("ab_iso_a", isolated, 0);
      tick(); chk("ab_iso_b", isolated, 0);
      isolate = 1'b0; aw_valid = 1'b1;
      tick(); chk("ab_iso_c", isolated, 0); chk("ab_gate_open", m_aw_valid, 1);
      aw_valid = 1'b0; b_done = 1'b1;
      tick(); chk("ab_cnt0", aw_cnt, 0);
      b_done = 1'b0;

      // Underflow on AR
      r_done = 1'b1;
      tick(); chk("uf_err", err, 1); chk("uf_cnt", ar_cnt, 0);
      r_done = 1'b0;
      tick(); chk("uf_err_clear", err, 0);

      // Saturation on the COUNTER_SIZE=2 instance
      b_aw_valid = 1'b1; b_aw_ready = 1'b1;
      tick(); tick(); tick();
      chk("sat_cnt3", b_aw_cnt, 3);
      chk("sat_aw_closed", b_m_aw_valid, 0);
      chk("sat_aw_ready_closed", b_s_aw_ready, 0);
      b_ar_valid = 1'b1;
      #1; chk("sat_ar_flows", b_m_ar_valid, 1);
      b_ar_valid = 1'b0;
      tick(); chk("sat_hold", b_aw_cnt, 3);
      b_b_done = 1'b1;
      tick(); chk("sat_cnt2", b_aw_cnt, 2); chk("sat_reopen", b_m_aw_valid, 1);
      b_b_done = 1'b0; b_aw_valid = 1'b0; b_aw_ready = 1'b0;

      // Reset mid-drain with 2 outstanding, then a stale completion
      aw_valid = 1'b1; aw_ready = 1'b1;
      tick(); tick();
      chk("rd_cnt2", aw_cnt, 2);
      aw_valid = 1'b0; aw_ready = 1'b0; isolate = 1'b1;
      tick(); chk("rd_in_drain", m_aw_valid, 0);
      aw_valid = 1'b1;
      #2; rst_n = 1'b0;
      #1;
      chk("rd_cnt_cleared", aw_cnt, 0);
      chk("rd_busy", busy, 0);
      chk("rd_state_run", m_aw_valid, 1);
      chk("rd_iso", isolated, 0);
      aw_valid = 1'b0; isolate = 1'b0;
      tick(); rst_n = 1'b1;
      b_done = 1'b1;
      tick(); chk("rd_stale_err", err, 1); chk("rd_stale_cnt", aw_cnt, 0);
      b_done = 1'b0;
      tick(); chk("rd_err_clear", err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
